// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 codes, address regions,
// default address map and store lane/byte-enable helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } f3_e;

    typedef enum logic [2:0] {
        RGN_RAM,
        RGN_OUT,
        RGN_SW,
        RGN_KEY,
        RGN_NONE
    } region_e;

    localparam int          DEF_DMEM_WORDS = 256;
    localparam logic [31:0] DEF_IO_BASE    = 32'h0000_0400;
    localparam int          DEF_NUM_HEX    = 8;
    localparam logic [31:0] DEF_SW_ADDR    = 32'h0000_0500;
    localparam int          DEF_SW_W       = 32;
    localparam int          DEF_KEY_W      = 4;

    // Size comes from funct3[1:0]; illegal codes are filtered by the caller.
    function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data across all lanes so byte enables pick the right copy.
    function automatic logic [31:0] wdat_rep(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {4{wd[7:0]}};
            2'b01:   r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extraction: picks the byte/halfword lane out of a 32-bit word and
// sign- or zero-extends it according to funct3.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_lane)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

        o_data = i_word;
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_data = {24'h0, w_byte};
            F3_HU:   o_data = {16'h0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/lsu_mmio.sv
// MEM-stage load/store unit: word RAM plus memory-mapped I/O window, one outstanding
// response behind a valid/ready pair, latency 1, full throughput.
module lsu_mmio
    import lsu_pkg::*;
#(
    parameter int          DMEM_WORDS = DEF_DMEM_WORDS,
    parameter logic [31:0] IO_BASE    = DEF_IO_BASE,
    parameter int          NUM_HEX    = DEF_NUM_HEX,
    parameter logic [31:0] SW_ADDR    = DEF_SW_ADDR,
    parameter int          SW_W       = DEF_SW_W,
    parameter int          KEY_W      = DEF_KEY_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [2:0]              req_funct3_i,
    input  logic [31:0]             req_addr_i,
    input  logic [31:0]             req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [31:0]             rsp_rdata_o,
    output logic                    rsp_err_o,
    input  logic [SW_W-1:0]         io_sw_i,
    input  logic [KEY_W-1:0]        io_key_i,
    output logic [NUM_HEX*32-1:0]   io_hex_o,
    output logic [31:0]             io_ledr_o,
    output logic [31:0]             io_ledg_o,
    output logic [31:0]             io_lcd_o
);

    localparam int          AW        = $clog2(DMEM_WORDS);
    localparam int          NUM_SLOTS = NUM_HEX + 3;
    localparam logic [31:0] RAM_BYTES = 32'(DMEM_WORDS * 4);
    localparam logic [31:0] IO_END    = IO_BASE + 32'(16 * NUM_SLOTS);
    localparam logic [31:0] KEY_ADDR  = SW_ADDR + 32'h10;

    logic [31:0]      r_mem [DMEM_WORDS];
    logic [31:0]      r_out [NUM_SLOTS];
    logic [SW_W-1:0]  r_sw_s1, r_sw_s2;
    logic [KEY_W-1:0] r_key_s1, r_key_s2;

    logic             r_rsp_valid, r_rsp_err, r_rsp_zero, r_rsp_ram;
    logic [2:0]       r_rsp_f3;
    logic [1:0]       r_rsp_lane;
    logic [31:0]      r_ram_q, r_io_q;

    region_e          w_rgn;
    logic             w_acc, w_f3_bad, w_misal, w_err;
    logic             w_ram_we, w_ram_re, w_out_we, w_io_re;
    logic [3:0]       w_be;
    logic [31:0]      w_wdat, w_slot, w_io_rd, w_ext;
    logic [AW-1:0]    w_widx;

    assign req_ready_o = !r_rsp_valid | rsp_ready_i;
    assign w_acc       = req_valid_i & req_ready_o;

    // Address decode in precedence order: RAM, output slots, switch, key.
    always_comb begin
        w_rgn = RGN_NONE;
        if (req_addr_i < RAM_BYTES)
            w_rgn = RGN_RAM;
        else if (req_addr_i >= IO_BASE && req_addr_i < IO_END)
            w_rgn = RGN_OUT;
        else if (req_addr_i[31:4] == SW_ADDR[31:4])
            w_rgn = RGN_SW;
        else if (req_addr_i[31:4] == KEY_ADDR[31:4])
            w_rgn = RGN_KEY;
    end

    assign w_f3_bad = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11);
    assign w_misal  = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                      (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);
    assign w_err    = w_f3_bad | w_misal | (w_rgn == RGN_NONE) |
                      (req_we_i & (w_rgn == RGN_SW || w_rgn == RGN_KEY));

    assign w_be     = be_gen(req_funct3_i, req_addr_i[1:0]);
    assign w_wdat   = wdat_rep(req_funct3_i, req_wdata_i);
    assign w_widx   = req_addr_i[AW+1:2];
    assign w_slot   = (req_addr_i - IO_BASE) >> 4;

    // Reset wins over a same-cycle request: nothing is written or read.
    assign w_ram_we = w_acc & !rst_i & !w_err &  req_we_i & (w_rgn == RGN_RAM);
    assign w_ram_re = w_acc & !rst_i & !w_err & !req_we_i & (w_rgn == RGN_RAM);
    assign w_out_we = w_acc & !w_err &  req_we_i & (w_rgn == RGN_OUT);
    assign w_io_re  = w_acc & !w_err & !req_we_i & (w_rgn != RGN_RAM);

    always_comb begin
        w_io_rd = '0;
        case (w_rgn)
            RGN_OUT: begin
                for (int k = 0; k < NUM_SLOTS; k++)
                    if (w_slot == 32'(k)) w_io_rd = r_out[k];
            end
            RGN_SW:  w_io_rd = 32'(r_sw_s2);
            RGN_KEY: w_io_rd = 32'(r_key_s2);
            default: w_io_rd = '0;
        endcase
    end

    // Kept free of reset so it maps onto block RAM with a registered read port.
    always_ff @(posedge clk_i) begin
        if (w_ram_we)
            for (int b = 0; b < 4; b++)
                if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wdat[8*b +: 8];
        if (w_ram_re)
            r_ram_q <= r_mem[w_widx];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_SLOTS; k++) r_out[k] <= '0;
        end else if (w_out_we) begin
            for (int k = 0; k < NUM_SLOTS; k++)
                if (w_slot == 32'(k))
                    for (int b = 0; b < 4; b++)
                        if (w_be[b]) r_out[k][8*b +: 8] <= w_wdat[8*b +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_key_s1 <= '0;
            r_key_s2 <= '0;
        end else begin
            r_sw_s1  <= io_sw_i;
            r_sw_s2  <= r_sw_s1;
            r_key_s1 <= io_key_i;
            r_key_s2 <= r_key_s1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_zero  <= 1'b1;
            r_rsp_ram   <= 1'b0;
            r_rsp_f3    <= '0;
            r_rsp_lane  <= '0;
            r_io_q      <= '0;
        end else if (w_acc) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_zero  <= w_err | req_we_i;
            r_rsp_ram   <= (w_rgn == RGN_RAM);
            r_rsp_f3    <= req_funct3_i;
            r_rsp_lane  <= req_addr_i[1:0];
            if (w_io_re) r_io_q <= w_io_rd;
        end else if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Extraction sits after the registers so the held response stays stable under backpressure.
    lsu_load_ext u_ext (
        .i_funct3 (r_rsp_f3),
        .i_lane   (r_rsp_lane),
        .i_word   (r_rsp_ram ? r_ram_q : r_io_q),
        .o_data   (w_ext)
    );

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_rdata_o = r_rsp_zero ? 32'h0 : w_ext;

    for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
        assign io_hex_o[32*k +: 32] = r_out[k];
    end
    assign io_ledr_o = r_out[NUM_HEX];
    assign io_ledg_o = r_out[NUM_HEX+1];
    assign io_lcd_o  = r_out[NUM_HEX+2];

endmodule

// File: tb/tb_lsu_mmio.sv
// Scoreboard bench for lsu_mmio: a small memory/IO model predicts every response,
// plus direct checks of outputs, backpressure and reset.
module tb_lsu_mmio;

    localparam int DW = 128;   // RAM ends at 0x200, so 0x200 is unmapped

    logic           clk = 1'b0;
    logic           rst_i, req_valid_i, req_ready_o, req_we_i;
    logic [2:0]     req_funct3_i;
    logic [31:0]    req_addr_i, req_wdata_i;
    logic           rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0]    rsp_rdata_o;
    logic [31:0]    io_sw_i;
    logic [3:0]     io_key_i;
    logic [255:0]   io_hex_o;
    logic [31:0]    io_ledr_o, io_ledg_o, io_lcd_o;

    lsu_mmio #(.DMEM_WORDS(DW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .io_sw_i(io_sw_i), .io_key_i(io_key_i),
        .io_hex_o(io_hex_o), .io_ledr_o(io_ledr_o), .io_ledg_o(io_ledg_o), .io_lcd_o(io_lcd_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        bit          lat;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0, n_fail = 0, cyc = 0;
    logic [31:0] mm [DW];
    logic [31:0] om [11];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: region decode, error rules, lane writes and load extension.
    function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output exp_t e);
        int rg, oi, mi;
        bit bad;
        logic [31:0] w, src, sh;
        rg = (a < DW*4) ? 0 : (a >= 32'h400 && a < 32'h4B0) ? 1 :
             (a[31:4] == 28'h50) ? 2 : (a[31:4] == 28'h51) ? 3 : 4;
        bad = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (f3[1:0] == 2'b01 && a[0]) ||
              (f3[1:0] == 2'b10 && a[1:0] != 2'b00) || rg == 4 || (we && rg >= 2);
        e.err = bad;
        e.rdata = 32'h0;
        if (bad) return;
        mi = int'(a >> 2);
        oi = int'((a - 32'h400) >> 4);
        w = (rg == 0) ? mm[mi] : (rg == 1) ? om[oi] : (rg == 2) ? io_sw_i : {28'h0, io_key_i};
        if (we) begin
            src = (f3[1:0] == 2'b10) ? wd : (f3[1:0] == 2'b01) ? {2{wd[15:0]}} : {4{wd[7:0]}};
            for (int b = 0; b < 4; b++)
                if (f3[1:0] == 2'b10 || (f3[1:0] == 2'b01 && (b / 2) == int'(a[1])) ||
                    (f3[1:0] == 2'b00 && b == int'(a[1:0])))
                    w[8*b +: 8] = src[8*b +: 8];
            if (rg == 0) mm[mi] = w; else om[oi] = w;
            return;
        end
        sh = w >> (8 * a[1:0]);
        case (f3)
            3'b000:  e.rdata = {{24{sh[7]}}, sh[7:0]};
            3'b001:  e.rdata = {{16{sh[15]}}, sh[15:0]};
            3'b100:  e.rdata = {24'h0, sh[7:0]};
            3'b101:  e.rdata = {16'h0, sh[15:0]};
            default: e.rdata = w;
        endcase
    endfunction

    task automatic req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input string tag);
        exp_t e;
        int k = 0;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
        req_addr_i = a; req_wdata_i = wd;
        forever begin
            #1;
            if (req_ready_o) break;
            k++;
            if (k > 50) begin
                chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
                req_valid_i = 1'b0;
                return;
            end
            @(negedge clk);
        end
        model(we, f3, a, wd, e);
        e.acc = cyc; e.lat = rsp_ready_i; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Response monitor: each consumed response is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid_o && rsp_ready_i) begin
                if (sb.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk({e.tag, "_rdata"}, rsp_rdata_o, e.rdata);
                    chk({e.tag, "_err"}, {31'h0, rsp_err_o}, {31'h0, e.err});
                    if (e.lat) chk({e.tag, "_lat"}, cyc - e.acc, 32'd1);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < DW; i++) mm[i] = 32'h0;
        for (int i = 0; i < 11; i++) om[i] = 32'h0;
        rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'b010;
        req_addr_i = 32'h0; req_wdata_i = 32'h0; rsp_ready_i = 1'b1;
        io_sw_i = 32'h0; io_key_i = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        chk("rst_rdata", rsp_rdata_o, 32'h0);
        chk("rst_err", {31'h0, rsp_err_o}, 32'h0);
        chk("rst_hex1", io_hex_o[63:32], 32'h0);
        chk("rst_ledr", io_ledr_o, 32'h0);
        chk("rst_lcd", io_lcd_o, 32'h0);
        chk("rst_ready", {31'h0, req_ready_o}, 32'h1);
        rst_i = 1'b0;

        // word store then load to the same word on the next edge
        req(1, 3'b010, 32'h000, 32'hDEADBEEF, "sw0");
        req(0, 3'b010, 32'h000, 32'h0, "lw0");
        // byte lane store and signed/unsigned loads
        req(1, 3'b000, 32'h003, 32'h00000080, "sb3");
        req(0, 3'b000, 32'h003, 32'h0, "lb3");
        req(0, 3'b100, 32'h003, 32'h0, "lbu3");
        req(0, 3'b010, 32'h000, 32'h0, "lw0b");
        req(1, 3'b010, 32'h004, 32'h11223344, "sw4");
        req(1, 3'b001, 32'h006, 32'h0000ABCD, "sh6");
        req(0, 3'b001, 32'h006, 32'h0, "lh6");
        req(0, 3'b101, 32'h004, 32'h0, "lhu4");
        req(0, 3'b010, 32'h004, 32'h0, "lw4");
        // errors
        req(0, 3'b001, 32'h001, 32'h0, "lh1_mis");
        req(1, 3'b010, 32'h002, 32'h55555555, "sw2_mis");
        req(0, 3'b010, 32'h000, 32'h0, "lw0_after_err");
        req(0, 3'b010, DW*4, 32'h0, "lw_unmap");
        req(0, 3'b011, 32'h000, 32'h0, "f3_bad");
        // output window
        req(1, 3'b010, 32'h410, 32'h12345678, "sw_hex1");
        req(1, 3'b010, 32'h480, 32'hA5A50F0F, "sw_ledr");
        req(1, 3'b000, 32'h49D, 32'h0000007E, "sb_ledg");
        req(0, 3'b010, 32'h49C, 32'h0, "lw_ledg");
        req(1, 3'b010, 32'h500, 32'h1, "sw_sw_ro");
        drain();
        chk("hex1", io_hex_o[63:32], 32'h12345678);
        chk("hex0", io_hex_o[31:0], 32'h0);
        chk("ledr", io_ledr_o, 32'hA5A50F0F);
        chk("ledg", io_ledg_o, 32'h00007E00);

        // synchronised inputs
        io_sw_i = 32'h0000A5A5;
        repeat (3) @(posedge clk);
        req(0, 3'b010, 32'h500, 32'h0, "lw_sw");
        req(0, 3'b000, 32'h501, 32'h0, "lb_sw1");
        io_key_i = 4'b1010;
        repeat (3) @(posedge clk);
        req(0, 3'b010, 32'h510, 32'h0, "lw_key");
        drain();

        // backpressure: response held for 3 cycles
        rsp_ready_i = 1'b0;
        req(0, 3'b010, 32'h000, 32'h0, "lw_hold");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("hold_ready", {31'h0, req_ready_o}, 32'h0);
            chk("hold_valid", {31'h0, rsp_valid_o}, 32'h1);
            chk("hold_rdata", rsp_rdata_o, 32'h80ADBEEF);
        end
        rsp_ready_i = 1'b1;
        #0.5;
        chk("release_ready", {31'h0, req_ready_o}, 32'h1);
        req(0, 3'b000, 32'h003, 32'h0, "lb_after_hold");
        drain();

        // reset mid-transfer
        rsp_ready_i = 1'b0;
        req(0, 3'b010, 32'h004, 32'h0, "lw_rst");
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        #1;
        sb.delete();
        for (int i = 0; i < 11; i++) om[i] = 32'h0;
        chk("mrst_valid", {31'h0, rsp_valid_o}, 32'h0);
        chk("mrst_rdata", rsp_rdata_o, 32'h0);
        chk("mrst_hex1", io_hex_o[63:32], 32'h0);
        chk("mrst_ledr", io_ledr_o, 32'h0);
        chk("mrst_ledg", io_ledg_o, 32'h0);

        // a request during reset neither writes nor responds
        req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b010;
        req_addr_i = 32'h000; req_wdata_i = 32'hFFFFFFFF;
        @(negedge clk);
        #1;
        chk("rstreq_valid", {31'h0, rsp_valid_o}, 32'h0);
        req_valid_i = 1'b0; rst_i = 1'b0; rsp_ready_i = 1'b1;
        req(0, 3'b010, 32'h000, 32'h0, "lw_after_rst");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
